// File: rtl/omsp_hash_frontend_gen.sv
// CPU-side frontend for the Sancus hash cores: beat packer, word FIFO,
// message sequencing and digest readout, all on a single clock.
module omsp_hash_frontend_gen #(
  parameter  int BUS_W      = 16,
  parameter  int CORE_W     = 32,
  parameter  int DIGEST_W   = 512,
  parameter  int FIFO_DEPTH = 4,
  localparam int NB_W       = $clog2(CORE_W/8)+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cmd_in,
  input  logic [BUS_W-1:0]  data,
  input  logic              data_size,
  output logic [BUS_W-1:0]  hash,
  output logic              busy,
  output logic              ready_for_data,
  output logic              overflow,
  output logic              core_start,
  output logic [CORE_W-1:0] core_data,
  output logic [NB_W-1:0]   core_nbytes,
  output logic              core_last,
  output logic              core_valid,
  input  logic              core_ready,
  input  logic [CORE_W-1:0] core_hash,
  input  logic              core_hash_valid,
  output logic              core_hash_ready
);

  localparam int CB  = CORE_W/8;
  localparam int BB  = BUS_W/8;
  localparam int NW  = DIGEST_W/CORE_W;
  localparam int NR  = DIGEST_W/BUS_W;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int DCW = $clog2(NW+1);
  localparam int RCW = $clog2(NR+1);

  typedef enum logic [2:0] {
    IDLE, ABSORB, FLUSH, DIGEST, READOUT
  } state_t;

  state_t state, state_nx;

  logic wr, rd, ab;
  logic [CORE_W-1:0] pk_word, word_nx;
  logic [NB_W-1:0]   pk_bytes, bytes_nx;
  logic wr_close, wr_acc, fin, need_term;
  logic mark_last, pend, push_flush;
  logic push, pop, full;
  logic [CORE_W-1:0] push_d;
  logic [NB_W-1:0]   push_n;
  logic              push_l;

  logic [CORE_W-1:0] mem_d [FIFO_DEPTH];
  logic [NB_W-1:0]   mem_n [FIFO_DEPTH];
  logic              mem_l [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;

  logic [DIGEST_W-1:0] dig;
  logic [DCW-1:0]      dcnt;
  logic [RCW-1:0]      rcnt;

  assign wr = cmd_in == 2'b10;
  assign rd = cmd_in == 2'b01;
  assign ab = cmd_in == 2'b11;

  assign core_valid = count != '0;
  assign full       = count == CW'(FIFO_DEPTH);
  assign pop        = core_valid && core_ready;

  assign core_data   = core_valid ? mem_d[rptr] : '0;
  assign core_nbytes = core_valid ? mem_n[rptr] : '0;
  assign core_last   = core_valid ? mem_l[rptr] : 1'b0;

  // Merge the incoming beat or byte at the next free byte lane, MSB-first
  always_comb begin
    bytes_nx = pk_bytes + (data_size ? NB_W'(BB) : NB_W'(1));
    if (data_size)
      word_nx = pk_word |
        (CORE_W'(data) << (CORE_W - BUS_W - 8*int'(pk_bytes)));
    else
      word_nx = pk_word |
        (CORE_W'(data[7:0]) << (CORE_W - 8 - 8*int'(pk_bytes)));
    wr_close = !data_size || bytes_nx == NB_W'(CB);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic; abort wins from every state
  always_comb begin
    state_nx = state;
    if (ab) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (wr_acc) state_nx = ABSORB;
        ABSORB:  if (rd) state_nx = FLUSH;
        FLUSH:   if (pop && mem_l[rptr]) state_nx = DIGEST;
        DIGEST:  if (core_hash_valid && dcnt == DCW'(NW-1))
                   state_nx = READOUT;
        READOUT: if (rd && rcnt == RCW'(NR-1)) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM outputs and handshake qualifiers
  always_comb begin
    busy            = state != IDLE;
    core_hash_ready = state == DIGEST;
    ready_for_data  = (state == IDLE || state == ABSORB) &&
                      (!full || !wr_close || pop);
    core_start      = state == IDLE && wr && ready_for_data;
    hash            = state == READOUT ? dig[DIGEST_W-1 -: BUS_W] : '0;
  end

  // Finalise either tags the newest queued word or defers a terminator push
  always_comb begin
    wr_acc     = wr && ready_for_data;
    fin        = state == ABSORB && rd;
    need_term  = pk_bytes != '0 || count == '0 ||
                 (count == CW'(1) && pop);
    mark_last  = fin && !need_term;
    push_flush = state == FLUSH && pend && (!full || pop);
    push       = (wr_acc && wr_close) || push_flush;
    push_d     = push_flush ? pk_word  : word_nx;
    push_n     = push_flush ? pk_bytes : bytes_nx;
    push_l     = push_flush;
  end

  // Packer, pending terminator and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_word  <= '0;
      pk_bytes <= '0;
      pend     <= 1'b0;
      overflow <= 1'b0;
    end else if (ab) begin
      pk_word  <= '0;
      pk_bytes <= '0;
      pend     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (wr_close) begin
          pk_word  <= '0;
          pk_bytes <= '0;
        end else begin
          pk_word  <= word_nx;
          pk_bytes <= bytes_nx;
        end
      end else if (push_flush) begin
        pk_word  <= '0;
        pk_bytes <= '0;
      end
      if (fin && need_term) pend <= 1'b1;
      else if (push_flush)  pend <= 1'b0;
      if (core_start)                overflow <= 1'b0;
      else if (wr && !ready_for_data) overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (ab) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push && !ab) begin
      mem_d[wptr] <= push_d;
      mem_n[wptr] <= push_n;
      mem_l[wptr] <= push_l;
    end
    if (mark_last && !ab) mem_l[wptr - AW'(1)] <= 1'b1;
  end

  // Digest capture from the core and beat-wise shift-out to the CPU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig  <= '0;
      dcnt <= '0;
      rcnt <= '0;
    end else if (ab) begin
      dig  <= '0;
      dcnt <= '0;
      rcnt <= '0;
    end else if (state == DIGEST && core_hash_valid) begin
      dig  <= (dig << CORE_W) | DIGEST_W'(core_hash);
      dcnt <= dcnt == DCW'(NW-1) ? '0 : dcnt + DCW'(1);
    end else if (state == READOUT && rd) begin
      dig  <= dig << BUS_W;
      rcnt <= rcnt == RCW'(NR-1) ? '0 : rcnt + RCW'(1);
    end
  end

endmodule

// File: tb/tb_omsp_hash_frontend_gen.sv
// Directed and randomized bench for omsp_hash_frontend_gen with a
// byte-queue message model and a popped-word scoreboard.
module tb_omsp_hash_frontend_gen;

  localparam int BUS_W      = 16;
  localparam int CORE_W     = 32;
  localparam int DIGEST_W   = 512;
  localparam int FIFO_DEPTH = 4;
  localparam int NW         = DIGEST_W/CORE_W;
  localparam int NR         = DIGEST_W/BUS_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd_in = 2'b00;
  logic [15:0] data = '0;
  logic        data_size = 1'b0;
  logic [15:0] hash;
  logic        busy, ready_for_data, overflow, core_start;
  logic [31:0] core_data;
  logic [2:0]  core_nbytes;
  logic        core_last, core_valid;
  logic        core_ready = 1'b0;
  logic [31:0] core_hash = '0;
  logic        core_hash_valid = 1'b0;
  logic        core_hash_ready;

  omsp_hash_frontend_gen #(
    .BUS_W(BUS_W), .CORE_W(CORE_W),
    .DIGEST_W(DIGEST_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .data(data),
    .data_size(data_size), .hash(hash), .busy(busy),
    .ready_for_data(ready_for_data), .overflow(overflow),
    .core_start(core_start), .core_data(core_data),
    .core_nbytes(core_nbytes), .core_last(core_last),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_hash(core_hash), .core_hash_valid(core_hash_valid),
    .core_hash_ready(core_hash_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  nb;
    logic        l;
  } wd_t;

  wd_t         exp_q[$];
  wd_t         got_q[$];
  logic [7:0]  m_part[$];
  int          m_cnt = 0;
  bit          m_busy = 0;
  bit          m_ovf = 0;
  logic [31:0] dw [NW];

  always @(negedge clk)
    if (!rst && core_valid && core_ready)
      got_q.push_back({core_data, core_nbytes, core_last});

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wd_t build(input bit last);
    logic [31:0] w = '0;
    for (int i = 0; i < m_part.size(); i++)
      w[31-8*i -: 8] = m_part[i];
    return {w, 3'(m_part.size()), last};
  endfunction

  task automatic model_clear();
    m_part.delete();
    exp_q.delete();
    got_q.delete();
    m_cnt  = 0;
    m_busy = 0;
    m_ovf  = 0;
  endtask

  task automatic wr(input bit sz, input logic [15:0] d);
    bit closes, acc, start;
    start = !m_busy;
    if (start) begin
      model_clear();
      m_busy = 1;
    end
    closes = !sz || (m_part.size() + 2 == 4);
    acc = (m_cnt < FIFO_DEPTH) || !closes;
    cmd_in = 2'b10; data_size = sz; data = d;
    #1;
    chk("ready_for_data", ready_for_data, acc);
    chk("core_start", core_start, start);
    tick();
    cmd_in = 2'b00;
    if (acc) begin
      if (sz) m_part.push_back(d[15:8]);
      m_part.push_back(d[7:0]);
      if (closes) begin
        exp_q.push_back(build(0));
        m_part.delete();
        m_cnt++;
      end
    end else begin
      m_ovf = 1;
    end
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic finalise();
    if (m_part.size() > 0) exp_q.push_back(build(1));
    else if (m_cnt > 0) exp_q[exp_q.size()-1].l = 1'b1;
    else exp_q.push_back({32'h0, 3'd0, 1'b1});
    m_part.delete();
    cmd_in = 2'b01;
    tick();
    cmd_in = 2'b00;
    chk("fin_busy", busy, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (!core_hash_ready && n < 300) begin
      core_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    core_ready = 1'b0;
    chk("reach_digest", core_hash_ready, 1);
    chk("n_words", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("word_data", got_q[i].d, exp_q[i].d);
      chk("word_nbytes", got_q[i].nb, exp_q[i].nb);
      chk("word_last", got_q[i].l, exp_q[i].l);
    end
  endtask

  task automatic digest();
    int k = 0;
    int n = 0;
    bit hs;
    while (k < NW && n < 400) begin
      core_hash_valid = ($urandom_range(0, 3) != 0);
      core_hash = dw[k];
      #1;
      hs = core_hash_valid && core_hash_ready;
      tick();
      if (hs) k++;
      n++;
    end
    core_hash_valid = 1'b0;
    chk("digest_words", k, NW);
  endtask

  task automatic readout();
    logic [31:0] w;
    for (int i = 0; i < NR; i++) begin
      w = dw[i/2];
      chk("hash_beat", hash, (i % 2 == 0) ? w[31:16] : w[15:0]);
      cmd_in = 2'b01;
      tick();
      cmd_in = 2'b00;
      if ($urandom_range(0, 1) == 1) tick();
    end
    chk("busy_after_read", busy, 0);
    m_busy = 0;
  endtask

  task automatic abort_cmd();
    cmd_in = 2'b11;
    tick();
    cmd_in = 2'b00;
    chk("abort_busy", busy, 0);
    chk("abort_valid", core_valid, 0);
    chk("abort_ovf", overflow, 0);
    model_clear();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready_for_data, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_hash", hash, 0);
    chk("rst_start", core_start, 0);
    chk("rst_valid", core_valid, 0);
    chk("rst_last", core_last, 0);
    chk("rst_nbytes", core_nbytes, 0);
    chk("rst_data", core_data, 0);
    chk("rst_hready", core_hash_ready, 0);
    rst = 1'b0;
    tick();

    core_ready = 1'b1;
    wr(1, 16'h0123);
    wr(1, 16'h4567);
    wr(1, 16'h89AB);
    wr(1, 16'hCDEF);
    repeat (3) tick();
    chk("t1_busy", busy, 1);
    chk("t1_nwords", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t1_w0", got_q[0].d, 32'h01234567);
      chk("t1_w0_nb", got_q[0].nb, 4);
      chk("t1_w1", got_q[1].d, 32'h89ABCDEF);
      chk("t1_w1_nb", got_q[1].nb, 4);
    end
    abort_cmd();

    core_ready = 1'b0;
    wr(1, 16'h1111);
    wr(0, 16'h0022);
    finalise();
    chk("t2_data", core_data, 32'h11112200);
    chk("t2_nbytes", core_nbytes, 3);
    chk("t2_last", core_last, 1);
    drain();
    for (int i = 0; i < NW; i++) dw[i] = 32'(i);
    digest();
    readout();

    core_ready = 1'b0;
    for (int i = 0; i < 10; i++) wr(1, 16'($urandom));
    chk("t3_ovf", overflow, 1);
    finalise();
    drain();
    for (int i = 0; i < NW; i++) dw[i] = $urandom;
    digest();
    readout();
    chk("t3_ovf_kept", overflow, m_ovf);

    core_ready = 1'b1;
    wr(1, 16'hAAAA);
    wr(1, 16'hBBBB);
    repeat (3) tick();
    m_cnt = 0;
    core_ready = 1'b0;
    finalise();
    drain();
    abort_cmd();

    core_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(1, 16'($urandom));
    chk("t5_valid", core_valid, 1);
    abort_cmd();
    wr(1, 16'h5555);
    for (int i = 0; i < 3; i++) wr(1, 16'($urandom));
    chk("t5_valid2", core_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", core_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ovf", overflow, 0);
    tick();
    rst = 1'b0;
    tick();
    model_clear();
    wr(1, 16'h7777);
    abort_cmd();

    for (int m = 0; m < 6; m++) begin
      int nw;
      core_ready = 1'b0;
      nw = $urandom_range(1, 11);
      for (int i = 0; i < nw; i++)
        wr($urandom_range(0, 3) != 0, 16'($urandom));
      finalise();
      drain();
      for (int i = 0; i < NW; i++) dw[i] = $urandom;
      digest();
      readout();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
